// File: rtl/mc6809_pkg.sv
// Shared definitions for the mc6809 E/Q clock-enable generator: phase encoding,
// speed encoding and an elaboration-time width helper.
package mc6809_pkg;

  typedef enum logic [2:0] {
    PH_Q0 = 3'd0,
    PH_Q1 = 3'd1,
    PH_Q2 = 3'd2,
    PH_Q3 = 3'd3,
    PH_QS = 3'd4
  } phase_t;

  localparam logic SPEED_SLOW = 1'b0;
  localparam logic SPEED_FAST = 1'b1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // {E, Q} levels shown while in a given phase.
  function automatic logic [1:0] phase_levels(input phase_t ph);
    logic [1:0] eq;
    case (ph)
      PH_Q0:   eq = 2'b00;
      PH_Q1:   eq = 2'b01;
      PH_Q2:   eq = 2'b11;
      PH_Q3:   eq = 2'b10;
      PH_QS:   eq = 2'b10;
      default: eq = 2'b00;
    endcase
    return eq;
  endfunction

endpackage

// File: rtl/mc6809_qtimer.sv
// Quarter-phase timer: counts 0..len_m1 and flags the last cycle of each quarter.
module mc6809_qtimer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] len_m1,
  output logic          end_of_quarter
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    end_of_quarter = (cnt_q == len_m1);
    cnt_d          = end_of_quarter ? '0 : cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc6809_clkgen.sv
// E/Q quadrature clock-enable generator with run-time speed select and
// capped MRDY-style stretching of the E-high phase.
module mc6809_clkgen
  import mc6809_pkg::*;
#(
  parameter int QUARTER_SLOW = 3,
  parameter int QUARTER_FAST = 1,
  parameter int STRETCH_MAX  = 10
) (
  input  logic CLK_ROOT,
  input  logic RESET,
  input  logic SPEED,
  input  logic nMRDY,
  output logic E,
  output logic Q,
  output logic CE_E_FALL,
  output logic CE_Q_FALL,
  output logic CE_E_RISE,
  output logic CE_Q_RISE,
  output logic STRETCHING
);

  localparam int QMAX = (QUARTER_SLOW > QUARTER_FAST) ? QUARTER_SLOW : QUARTER_FAST;
  localparam int TW   = clog2_min1(QMAX);
  localparam int SW   = clog2_min1(STRETCH_MAX + 1);

  localparam logic [TW-1:0] SLOW_M1     = TW'(QUARTER_SLOW - 1);
  localparam logic [TW-1:0] FAST_M1     = TW'(QUARTER_FAST - 1);
  localparam logic [SW-1:0] STRETCH_LIM = SW'(STRETCH_MAX);

  phase_t        phase_q, phase_d;
  logic [SW-1:0] stretch_cnt_q, stretch_cnt_d;
  logic          spd_q, spd_d;
  logic          e_q, e_d;
  logic          q_q, q_d;
  logic          stretching_q, stretching_d;

  logic          eoq;
  logic [TW-1:0] len_m1;
  logic          ce_e_fall, ce_q_fall, ce_e_rise, ce_q_rise;

  // Quarter length only changes at E-fall, which is also a timer restart.
  assign len_m1 = (spd_q == SPEED_FAST) ? FAST_M1 : SLOW_M1;

  mc6809_qtimer #(.TW(TW)) u_qtimer (
    .clk            (CLK_ROOT),
    .rst            (RESET),
    .len_m1         (len_m1),
    .end_of_quarter (eoq)
  );

  always_comb begin
    phase_d       = phase_q;
    stretch_cnt_d = stretch_cnt_q;
    spd_d         = spd_q;
    ce_e_fall     = 1'b0;
    ce_q_fall     = 1'b0;
    ce_e_rise     = 1'b0;
    ce_q_rise     = 1'b0;
    if (eoq) begin
      case (phase_q)
        PH_Q0: begin
          ce_q_rise = 1'b1;
          phase_d   = PH_Q1;
        end
        PH_Q1: begin
          ce_e_rise = 1'b1;
          phase_d   = PH_Q2;
        end
        PH_Q2: begin
          ce_q_fall = 1'b1;
          phase_d   = PH_Q3;
        end
        PH_Q3, PH_QS: begin
          if (!nMRDY && (stretch_cnt_q < STRETCH_LIM)) begin
            phase_d       = PH_QS;
            stretch_cnt_d = stretch_cnt_q + SW'(1);
          end else begin
            ce_e_fall     = 1'b1;
            phase_d       = PH_Q0;
            stretch_cnt_d = '0;
            spd_d         = SPEED;
          end
        end
        default: phase_d = PH_Q0;
      endcase
    end
    {e_d, q_d}   = phase_levels(phase_d);
    stretching_d = (phase_d == PH_QS);
  end

  always_ff @(posedge CLK_ROOT) begin
    if (RESET) begin
      phase_q       <= PH_Q0;
      stretch_cnt_q <= '0;
      spd_q         <= SPEED_SLOW;
      e_q           <= 1'b0;
      q_q           <= 1'b0;
      stretching_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      stretch_cnt_q <= stretch_cnt_d;
      spd_q         <= spd_d;
      e_q           <= e_d;
      q_q           <= q_d;
      stretching_q  <= stretching_d;
    end
  end

  // With one-cycle quarters the timer ends every cycle, so strobes are held off under reset.
  assign CE_E_FALL  = ce_e_fall & ~RESET;
  assign CE_Q_FALL  = ce_q_fall & ~RESET;
  assign CE_E_RISE  = ce_e_rise & ~RESET;
  assign CE_Q_RISE  = ce_q_rise & ~RESET;
  assign E          = e_q;
  assign Q          = q_q;
  assign STRETCHING = stretching_q;

endmodule

// File: tb/tb_mc6809_clkgen.sv
// Directed bench for mc6809_clkgen: a default instance driven from a vector table
// and a one-cycle-quarter, no-stretch instance checked with a short hand sequence.
module tb_mc6809_clkgen;

  typedef struct {
    logic       rst;
    logic       spd;
    logic       nmrdy;
    logic [6:0] exp;  // {E, Q, CE_E_FALL, CE_Q_FALL, CE_E_RISE, CE_Q_RISE, STRETCHING}
  } vec_t;

  logic clk;
  logic rst, spd, nmrdy;
  logic e, q, ce_ef, ce_qf, ce_er, ce_qr, stretching;
  logic rst1, spd1, nmrdy1;
  logic e1, q1, ce_ef1, ce_qf1, ce_er1, ce_qr1, stretching1;

  int tests;
  int failed;
  vec_t vecs[$];

  logic [6:0] slow_pat [12] = '{
    7'b0000000, 7'b0000000, 7'b0000010,
    7'b0100000, 7'b0100000, 7'b0100100,
    7'b1100000, 7'b1100000, 7'b1101000,
    7'b1000000, 7'b1000000, 7'b1010000
  };
  logic [6:0] fast_pat [4] = '{7'b0000010, 7'b0100100, 7'b1101000, 7'b1010000};

  localparam logic [6:0] E_HI   = 7'b1000000;
  localparam logic [6:0] E_STR  = 7'b1000001;
  localparam logic [6:0] E_STRF = 7'b1010001;
  localparam logic [6:0] ALL0   = 7'b0000000;

  mc6809_clkgen dut (
    .CLK_ROOT   (clk),
    .RESET      (rst),
    .SPEED      (spd),
    .nMRDY      (nmrdy),
    .E          (e),
    .Q          (q),
    .CE_E_FALL  (ce_ef),
    .CE_Q_FALL  (ce_qf),
    .CE_E_RISE  (ce_er),
    .CE_Q_RISE  (ce_qr),
    .STRETCHING (stretching)
  );

  mc6809_clkgen #(.QUARTER_SLOW(1), .QUARTER_FAST(1), .STRETCH_MAX(0)) dut1 (
    .CLK_ROOT   (clk),
    .RESET      (rst1),
    .SPEED      (spd1),
    .nMRDY      (nmrdy1),
    .E          (e1),
    .Q          (q1),
    .CE_E_FALL  (ce_ef1),
    .CE_Q_FALL  (ce_qf1),
    .CE_E_RISE  (ce_er1),
    .CE_Q_RISE  (ce_qr1),
    .STRETCHING (stretching1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic add(input logic r, input logic s, input logic n, input logic [6:0] x);
    vec_t v;
    v.rst   = r;
    v.spd   = s;
    v.nmrdy = n;
    v.exp   = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: outs got %b expected %b", name, got, want);
    end
  endtask

  task automatic build_table();
    add(1, 0, 1, ALL0);
    add(1, 0, 1, ALL0);
    // Slow period; SPEED/nMRDY wiggle but are only sampled at E-fall
    for (int c = 0; c < 12; c++) add(0, c < 11, c < 11 ? 1'b0 : 1'b1, slow_pat[c]);
    // Slow period with SPEED raised mid-Q1
    for (int c = 0; c < 12; c++) add(0, c >= 4, 1, slow_pat[c]);
    for (int c = 0; c < 4; c++) add(0, 1, 1, fast_pat[c]);
    for (int c = 0; c < 4; c++) add(0, c < 3, 1, fast_pat[c]);
    // Slow period with two stretch quarters
    for (int c = 0; c < 18; c++)
      add(0, 0, (c >= 9 && c <= 14) ? 1'b0 : 1'b1,
          c < 11 ? slow_pat[c] : c == 11 ? E_HI : c < 17 ? E_STR : E_STRF);
    // nMRDY stuck low: ten stretches then forced E-fall
    for (int c = 0; c < 42; c++)
      add(0, 1, 0, c < 11 ? slow_pat[c] : c == 11 ? E_HI : c < 41 ? E_STR : E_STRF);
    // Fast period stretching again, reset lands in the third stretch quarter
    add(0, 1, 0, 7'b0000010);
    add(0, 1, 0, 7'b0100100);
    add(0, 1, 0, 7'b1101000);
    add(0, 1, 0, E_HI);
    add(0, 1, 0, E_STR);
    add(0, 1, 0, E_STR);
    add(1, 1, 0, E_STR);
    add(1, 1, 0, ALL0);
    add(1, 1, 0, ALL0);
    // Back to slow after reset even with SPEED high
    for (int c = 0; c < 12; c++) add(0, 1, 1, slow_pat[c]);
  endtask

  // Scoreboard / main sequence
  initial begin
    logic [6:0] got;
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    spd    = 1'b0;
    nmrdy  = 1'b1;
    rst1   = 1'b1;
    spd1   = 1'b0;
    nmrdy1 = 1'b0;
    build_table();
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      spd   = vecs[i].spd;
      nmrdy = vecs[i].nmrdy;
      #1;
      got = {e, q, ce_ef, ce_qf, ce_er, ce_qr, stretching};
      check($sformatf("vec[%0d]", i), got, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // One-cycle quarters, stretching disabled, nMRDY held low
    for (int i = 0; i < 2; i++) begin
      #1;
      got = {e1, q1, ce_ef1, ce_qf1, ce_er1, ce_qr1, stretching1};
      check($sformatf("fast1_reset[%0d]", i), got, ALL0);
      @(posedge clk);
      #1;
    end
    rst1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      spd1 = 1'($urandom_range(0, 1));
      #1;
      got = {e1, q1, ce_ef1, ce_qf1, ce_er1, ce_qr1, stretching1};
      check($sformatf("fast1_run[%0d]", i), got, fast_pat[i % 4]);
      @(posedge clk);
      #1;
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
